multi_delay_timer: RTL and testbench

Multi-channel programmable delay timer, the parametrised successor of the single fixed-period delay counter. Each channel counts to its own run-time programmable period and emits a one-cycle `sig` pulse. A channel runs in periodic or one-shot mode. Period reprogramming is glitch-free: a new period takes effect only at a wrap or while the channel is stopped. A sticky `err` flags any count-beyond-period violation. It serves as the timing source for protocol watchdogs and as a formal safety+liveness benchmark.

---
 rtl/multi_delay_pkg.sv | 31 +++
 rtl/delay_channel.sv | 163 ++++++++++++++++
 rtl/multi_delay_timer.sv | 61 ++++++
 tb/tb_multi_delay_timer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_delay_pkg.sv
// =============================================================================
// Module      : multi_delay_pkg
// Description : Shared types and default constants for the multi-channel delay timer.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package multi_delay_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chan_state_t;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_t;

    localparam int c_CBITS     = 13;
    localparam int c_DEFAULT_N = 7500;

    // Maps the raw one-shot config bit onto the mode encoding.
    function automatic mode_t to_mode(input logic oneshot);
        return oneshot ? MODE_ONESHOT : MODE_PERIODIC;
    endfunction

endpackage

`default_nettype wire

// File: rtl/delay_channel.sv
// =============================================================================
// Module      : delay_channel
// Description : One timer channel: IDLE/RUN/DONE FSM, counter, shadowed period/mode.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module delay_channel
    import multi_delay_pkg::*;
#(
    parameter int CBITS     = c_CBITS,
    parameter int DEFAULT_N = c_DEFAULT_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_cfg_we,
    input  logic [CBITS-1:0] i_cfg_period,
    input  logic             i_cfg_oneshot,
    output logic             o_sig,
    output logic             o_flg,
    output logic             o_done,
    output logic             o_err
);

    localparam logic [CBITS-1:0] c_RST_PERIOD = CBITS'(DEFAULT_N);

    chan_state_t      r_state;
    chan_state_t      w_state_nxt;
    logic [CBITS-1:0] r_cnt;
    logic [CBITS-1:0] r_period_act;
    logic [CBITS-1:0] r_period_shd;
    mode_t            r_mode_act;
    mode_t            r_mode_shd;
    logic             r_err;

    logic             w_at_period;
    logic             w_below_period;
    logic             w_over_period;
    logic             w_load_act;

    assign w_at_period    = (r_cnt == r_period_act);
    assign w_below_period = (r_cnt <  r_period_act);
    assign w_over_period  = (r_cnt >  r_period_act);

    // Active values only move when the channel is not mid-period, so a new
    // period can never cut the running one short or stretch it past its end.
    assign w_load_act = (r_state != RUN) || w_at_period;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (i_en) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (!i_en) begin
                    w_state_nxt = IDLE;
                end else if (w_at_period && (r_mode_act == MODE_ONESHOT)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (!i_en) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        o_sig  = 1'b0;
        o_flg  = 1'b0;
        o_done = 1'b0;
        case (r_state)
            RUN: begin
                o_sig = w_at_period;
                o_flg = w_below_period;
            end
            DONE: begin
                o_done = 1'b1;
            end
            default: begin
                o_sig  = 1'b0;
            end
        endcase
    end

    assign o_err = r_err;

    // -------------------------------------------------------------------------
    // Counter: advances only while running below the period, else returns to 0
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((r_state == RUN) && i_en && !w_at_period) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // -------------------------------------------------------------------------
    // Shadow and active configuration
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_period_shd <= c_RST_PERIOD;
            r_mode_shd   <= MODE_PERIODIC;
        end else if (i_cfg_we) begin
            r_period_shd <= i_cfg_period;
            r_mode_shd   <= to_mode(i_cfg_oneshot);
        end
    end

    // Copies the pre-write shadow when a write lands on a wrap cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_period_act <= c_RST_PERIOD;
            r_mode_act   <= MODE_PERIODIC;
        end else if (w_load_act) begin
            r_period_act <= r_period_shd;
            r_mode_act   <= r_mode_shd;
        end
    end

    // -------------------------------------------------------------------------
    // Sticky overrun flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((r_state == RUN) && w_over_period) begin
            r_err <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/multi_delay_timer.sv
// =============================================================================
// Module      : multi_delay_timer
// Description : Array of independent programmable delay channels with a shared config port.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module multi_delay_timer
    import multi_delay_pkg::*;
#(
    parameter int  CHANNELS  = 4,
    parameter int  CBITS     = c_CBITS,
    parameter int  DEFAULT_N = c_DEFAULT_N,
    localparam int CFG_CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                cfg_we,
    input  logic [CFG_CH_W-1:0] cfg_ch,
    input  logic [CBITS-1:0]    cfg_period,
    input  logic                cfg_oneshot,
    output logic [CHANNELS-1:0] sig,
    output logic [CHANNELS-1:0] flg,
    output logic [CHANNELS-1:0] done,
    output logic [CHANNELS-1:0] err
);

    logic [CHANNELS-1:0] w_ch_we;

    // Channel indices with no matching instance decode to no strobe at all.
    always_comb begin
        w_ch_we = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_we && (int'(cfg_ch) == i)) begin
                w_ch_we[i] = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        delay_channel #(
            .CBITS     (CBITS),
            .DEFAULT_N (DEFAULT_N)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .i_en          (en[gi]),
            .i_cfg_we      (w_ch_we[gi]),
            .i_cfg_period  (cfg_period),
            .i_cfg_oneshot (cfg_oneshot),
            .o_sig         (sig[gi]),
            .o_flg         (flg[gi]),
            .o_done        (done[gi]),
            .o_err         (err[gi])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_multi_delay_timer.sv
// =============================================================================
// Module      : tb_multi_delay_timer
// Description : Directed self-checking bench for multi_delay_timer (4 channels, 13-bit).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_multi_delay_timer;

    logic        clk;
    logic        rst;
    logic [3:0]  en;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [12:0] cfg_period;
    logic        cfg_oneshot;
    logic [3:0]  sig;
    logic [3:0]  flg;
    logic [3:0]  done;
    logic [3:0]  err;

    int n_tests;
    int n_fail;

    multi_delay_timer #(
        .CHANNELS  (4),
        .CBITS     (13),
        .DEFAULT_N (7500)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_oneshot (cfg_oneshot),
        .sig         (sig),
        .flg         (flg),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [12:0] period, input logic oneshot);
        cfg_we      = 1'b1;
        cfg_ch      = ch;
        cfg_period  = period;
        cfg_oneshot = oneshot;
        tick();
        cfg_we      = 1'b0;
    endtask

    initial begin
        int pulses;
        int s0_cnt, s0_first, s0_second;
        int s2_cnt, s2_first, s2_second;
        int other_cnt;

        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        en          = 4'b0000;
        cfg_we      = 1'b0;
        cfg_ch      = 2'd0;
        cfg_period  = 13'd0;
        cfg_oneshot = 1'b0;
        tick();
        tick();

        // ---------------- reset state ----------------
        chk4("rst_sig",  sig,  4'b0000);
        chk4("rst_flg",  flg,  4'b0000);
        chk4("rst_done", done, 4'b0000);
        chk4("rst_err",  err,  4'b0000);
        rst = 1'b0;
        tick();

        // ---------------- ch0 periodic, period 3 ----------------
        cfg_write(2'd0, 13'd3, 1'b0);
        tick();
        en[0] = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            chk1($sformatf("p3_sig_k%0d", k), sig[0], (k % 4) == 3);
            chk1($sformatf("p3_flg_k%0d", k), flg[0], (k % 4) != 3);
            tick();
        end
        chk4("p3_err", err, 4'b0000);
        en[0] = 1'b0;
        tick();
        chk1("p3_idle_flg", flg[0], 1'b0);

        // ---------------- ch1 one-shot, period 5 ----------------
        cfg_write(2'd1, 13'd5, 1'b1);
        tick();
        en[1] = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            chk1($sformatf("os_sig_k%0d", k), sig[1], k == 5);
            chk1($sformatf("os_done_k%0d", k), done[1], 1'b0);
            tick();
        end
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            chk1($sformatf("os_done_hold%0d", k), done[1], 1'b1);
            if (sig[1]) pulses++;
            tick();
        end
        chki("os_no_retrigger", pulses, 0);
        en[1] = 1'b0;
        tick();
        chk1("os_done_clear", done[1], 1'b0);
        chk1("os_idle_flg", flg[1], 1'b0);

        // ---------------- ch2 reprogram 10 -> 2 at cnt 7 ----------------
        cfg_write(2'd2, 13'd10, 1'b0);
        tick();
        en[2] = 1'b1;
        tick();
        for (int k = 0; k < 7; k++) tick();
        cfg_write(2'd2, 13'd2, 1'b0);
        chk1("rp_sig_c8", sig[2], 1'b0);
        chk1("rp_flg_c8", flg[2], 1'b1);
        tick();
        chk1("rp_sig_c9", sig[2], 1'b0);
        tick();
        chk1("rp_sig_c10", sig[2], 1'b1);
        chk1("rp_flg_c10", flg[2], 1'b0);
        tick();
        for (int j = 0; j < 6; j++) begin
            chk1($sformatf("rp_p2_sig_j%0d", j), sig[2], (j % 3) == 2);
            tick();
        end
        tick();
        tick();
        chk1("rp_wrap_sig", sig[2], 1'b1);
        // write lands on a sig cycle: old shadow (2) governs one more period
        cfg_write(2'd2, 13'd4, 1'b0);
        for (int j = 0; j < 3; j++) begin
            chk1($sformatf("rp_old_sig_j%0d", j), sig[2], j == 2);
            tick();
        end
        for (int j = 0; j < 5; j++) begin
            chk1($sformatf("rp_new_sig_j%0d", j), sig[2], j == 4);
            tick();
        end
        en[2] = 1'b0;
        tick();
        chk4("rp_err", err, 4'b0000);

        // ---------------- ch3 period 0, then abort ----------------
        cfg_write(2'd3, 13'd0, 1'b0);
        tick();
        en[3] = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk1($sformatf("p0_sig_k%0d", k), sig[3], 1'b1);
            chk1($sformatf("p0_flg_k%0d", k), flg[3], 1'b0);
            tick();
        end
        en[3] = 1'b0;
        tick();
        chk1("p0_stop_sig", sig[3], 1'b0);
        cfg_write(2'd3, 13'd6, 1'b0);
        tick();
        en[3] = 1'b1;
        tick();
        tick();
        tick();
        tick();
        en[3] = 1'b0;
        tick();
        chk1("ab_sig", sig[3], 1'b0);
        chk1("ab_flg", flg[3], 1'b0);
        en[3] = 1'b1;
        tick();
        for (int k = 0; k < 7; k++) begin
            chk1($sformatf("ab_restart_sig_k%0d", k), sig[3], k == 6);
            tick();
        end
        en[3] = 1'b0;
        tick();

        // ---------------- reset mid-count with simultaneous config write ----------------
        en[0] = 1'b1;
        tick();
        tick();
        tick();
        rst         = 1'b1;
        cfg_we      = 1'b1;
        cfg_ch      = 2'd0;
        cfg_period  = 13'd2;
        cfg_oneshot = 1'b1;
        tick();
        chk4("mr_sig",  sig,  4'b0000);
        chk4("mr_flg",  flg,  4'b0000);
        chk4("mr_done", done, 4'b0000);
        chk4("mr_err",  err,  4'b0000);
        rst    = 1'b0;
        cfg_we = 1'b0;
        en     = 4'b0000;
        tick();

        // ---------------- default period 7500, staggered channels ----------------
        s0_cnt = 0; s0_first = -1; s0_second = -1;
        s2_cnt = 0; s2_first = -1; s2_second = -1;
        other_cnt = 0;
        en = 4'b0001;
        tick();
        for (int t = 0; t <= 15010; t++) begin
            if (sig[0]) begin
                if (s0_cnt == 0) s0_first = t;
                else if (s0_cnt == 1) s0_second = t;
                s0_cnt++;
            end
            if (sig[2]) begin
                if (s2_cnt == 0) s2_first = t;
                else if (s2_cnt == 1) s2_second = t;
                s2_cnt++;
            end
            if (sig[1] || sig[3]) other_cnt++;
            if (t == 7499) chk1("dflt_flg_7499", flg[0], 1'b1);
            if (t == 4) en[2] = 1'b1;
            tick();
        end
        chki("dflt_ch0_first",  s0_first,  7500);
        chki("dflt_ch0_second", s0_second, 15001);
        chki("dflt_ch0_count",  s0_cnt,    2);
        chki("dflt_ch2_first",  s2_first,  7505);
        chki("dflt_ch2_second", s2_second, 15006);
        chki("dflt_ch2_count",  s2_cnt,    2);
        chki("dflt_idle_chans", other_cnt, 0);
        chk4("dflt_err", err, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
